// File: rtl/nios_multi_timer_pkg.sv
// Shared definitions for the multi-channel interval timer: register offsets,
// CONTROL bit positions and the per-channel write-strobe bundle.
package nios_multi_timer_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_sel_e;

  localparam int CTL_ITO     = 0;
  localparam int CTL_CONT    = 1;
  localparam int CTL_START   = 2;
  localparam int CTL_STOP    = 3;
  localparam int CTL_PRE_LSB = 4;

  typedef struct packed {
    logic status;
    logic control;
    logic period;
    logic snap;
  } ch_wr_t;

  // Width of the channel field of the word address; at least one bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/nios_multi_timer_if.sv
// Avalon-MM slave port of the timer plus its interrupt outputs.
interface nios_multi_timer_if #(
  parameter int NUM_CH = 4
) ();
  localparam int ADDR_W = $clog2(NUM_CH) + 2;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq, irq_vec
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq, irq_vec
  );
endinterface

// File: rtl/nios_multi_timer_channel.sv
// One timer channel: prescaled down-counter with period, control, snapshot,
// run and sticky timeout state; exposes its four read words and its irq.
module nios_multi_timer_channel
  import nios_multi_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  ch_wr_t      i_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rd_status,
  output logic [31:0] o_rd_control,
  output logic [31:0] o_rd_period,
  output logic [31:0] o_rd_snap,
  output logic        o_irq
);

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_snap;
  logic [PRE_W-1:0] r_pcnt;
  logic [PRE_W-1:0] r_pre;
  logic             r_cont;
  logic             r_ito;
  logic             r_run;
  logic             r_to;
  logic             r_load;

  logic w_start;
  logic w_stop;
  logic w_tick;
  logic w_event;

  assign w_start = i_we.control && i_wdata[CTL_START];
  assign w_stop  = i_we.control && i_wdata[CTL_STOP];
  assign w_tick  = r_run && (r_pcnt == r_pre);
  // A pending force-load owns the counter, so it can never also time out.
  assign w_event = w_tick && !r_load && (r_count == {CNT_W{1'b0}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre    <= {PRE_W{1'b0}};
      r_cont   <= 1'b0;
      r_ito    <= 1'b0;
      r_period <= RST_CNT;
      r_load   <= 1'b0;
      r_snap   <= {CNT_W{1'b0}};
    end else begin
      if (i_we.control) begin
        r_pre  <= i_wdata[CTL_PRE_LSB +: PRE_W];
        r_cont <= i_wdata[CTL_CONT];
        r_ito  <= i_wdata[CTL_ITO];
      end
      if (i_we.period) begin
        r_period <= i_wdata[CNT_W-1:0];
      end
      r_load <= i_we.period;
      if (i_we.snap) begin
        r_snap <= r_count;
      end
    end
  end

  // Start beats stop; a PERIOD write or a one-shot timeout halts the channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= 1'b0;
      r_to  <= 1'b0;
    end else begin
      if (w_start) begin
        r_run <= 1'b1;
      end else if (w_stop || i_we.period || (w_event && !r_cont)) begin
        r_run <= 1'b0;
      end
      if (w_event) begin
        r_to <= 1'b1;
      end else if (i_we.status) begin
        r_to <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= RST_CNT;
      r_pcnt  <= {PRE_W{1'b0}};
    end else begin
      if (r_load) begin
        r_count <= r_period;
      end else if (w_tick) begin
        r_count <= (r_count == {CNT_W{1'b0}}) ? r_period : (r_count - CNT_W'(1));
      end
      if (w_start || r_load || !r_run || w_tick) begin
        r_pcnt <= {PRE_W{1'b0}};
      end else begin
        r_pcnt <= r_pcnt + PRE_W'(1);
      end
    end
  end

  assign o_rd_status  = {30'd0, r_run, r_to};
  assign o_rd_control = 32'({r_pre, 2'b00, r_cont, r_ito});
  assign o_rd_period  = 32'(r_period);
  assign o_rd_snap    = 32'(r_snap);
  assign o_irq        = r_to && r_ito;

endmodule

// File: rtl/nios_multi_timer.sv
// Multi-channel interval timer top: address decode, read mux, registered
// readdata and interrupt outputs around NUM_CH channel instances.
module nios_multi_timer
  import nios_multi_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                clk,
  input  logic                reset_n,
  nios_multi_timer_if.slave   bus
);

  localparam int ADDR_W = $clog2(NUM_CH) + 2;
  localparam int CH_W   = ch_idx_w(NUM_CH);

  logic [CH_W-1:0]   w_ch;
  logic [1:0]        w_reg;
  logic              w_wr;
  logic [31:0]       w_rdata;
  logic [31:0]       w_word [NUM_CH];
  logic [NUM_CH-1:0] w_irq;

  logic [31:0]       r_readdata;
  logic [NUM_CH-1:0] r_irq_vec;
  logic              r_irq;

  if (NUM_CH > 1) begin : g_ch_sel
    assign w_ch = bus.address[ADDR_W-1:2];
  end else begin : g_ch_zero
    assign w_ch = {CH_W{1'b0}};
  end

  assign w_reg = bus.address[1:0];
  assign w_wr  = bus.chipselect && !bus.write_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_wr_t      w_we;
    logic        w_hit;
    logic [31:0] w_status;
    logic [31:0] w_control;
    logic [31:0] w_period;
    logic [31:0] w_snap;

    assign w_hit        = (w_ch == CH_W'(g));
    assign w_we.status  = w_wr && w_hit && (w_reg == REG_STATUS);
    assign w_we.control = w_wr && w_hit && (w_reg == REG_CONTROL);
    assign w_we.period  = w_wr && w_hit && (w_reg == REG_PERIOD);
    assign w_we.snap    = w_wr && w_hit && (w_reg == REG_SNAP);

    nios_multi_timer_channel #(
      .CNT_W        (CNT_W),
      .PRE_W        (PRE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_channel (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_we         (w_we),
      .i_wdata      (bus.writedata),
      .o_rd_status  (w_status),
      .o_rd_control (w_control),
      .o_rd_period  (w_period),
      .o_rd_snap    (w_snap),
      .o_irq        (w_irq[g])
    );

    always_comb begin
      w_word[g] = 32'd0;
      case (reg_sel_e'(w_reg))
        REG_STATUS:  w_word[g] = w_status;
        REG_CONTROL: w_word[g] = w_control;
        REG_PERIOD:  w_word[g] = w_period;
        REG_SNAP:    w_word[g] = w_snap;
        default:     w_word[g] = 32'd0;
      endcase
    end
  end

  // Addresses naming a channel beyond NUM_CH match no instance and read 0.
  always_comb begin
    w_rdata = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_rdata = w_rdata | ((w_ch == CH_W'(i)) ? w_word[i] : 32'd0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
      r_irq_vec  <= {NUM_CH{1'b0}};
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= w_rdata;
      r_irq_vec  <= w_irq;
      r_irq      <= |w_irq;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq_vec  = r_irq_vec;
  assign bus.irq      = r_irq;

endmodule
